// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Consumes one-cycle byte strobes from a UART receiver. It parses frames of the form
//   SYNC, LEN, LEN payload bytes, CSUM. The checksum is the mod-256 sum of LEN and the payload.
//   A frame's payload is buffered in full before it is released. Good frames drain as a
//   valid/ready byte stream. Bad frames, inter-byte timeouts and bytes arriving during a drain
//   are reported as one-cycle error pulses with a code.
// Ports
//   i_Clock, i_Reset               clock; synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte             byte strobe and data from the UART receiver
//   o_Frame_Byte, o_Frame_Valid    payload stream out
//   i_Frame_Ready, o_Frame_Last    consumer ready; marks the final payload byte
//   o_Frame_Done                   pulse after the last byte is accepted
//   o_Frame_Err, o_Err_Code        error pulse; 0=bad LEN, 1=checksum, 2=timeout, 3=overrun
//   o_Busy                         high whenever the parser is not idle
module uart_frame_parser #(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 8700
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic [7:0] o_Frame_Byte,
  output logic       o_Frame_Valid,
  input  logic       i_Frame_Ready,
  output logic       o_Frame_Last,
  output logic       o_Frame_Done,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  localparam logic [7:0]    MaxLenByte = 8'(MAX_LEN);
  localparam logic [TW-1:0] TmoLimit   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [LW-1:0] LenOne     = LW'(1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLen     = 3'd1;
  localparam logic [2:0] StPayload = 3'd2;
  localparam logic [2:0] StCsum    = 3'd3;
  localparam logic [2:0] StDrain   = 3'd4;

  localparam logic [1:0] ErrLen     = 2'd0;
  localparam logic [1:0] ErrCsum    = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrOverrun = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          buf_we;
  logic          in_frame;
  logic          last_byte;

  // Payload store; contents are don't-care after reset, so no reset on this array.
  logic [7:0] buf_q [MAX_LEN];

  assign in_frame  = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
  assign last_byte = (rd_idx_q == (len_q - LenOne));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    rd_idx_d = rd_idx_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = 2'd0;
    buf_we   = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = StLen;
          tmo_d   = '0;
        end
      end
      StLen: begin
        if (i_Rx_DV) begin
          tmo_d = '0;
          if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MaxLenByte)) begin
            err_d   = 1'b1;
            code_d  = ErrLen;
            state_d = StIdle;
          end else begin
            len_d   = i_Rx_Byte[LW-1:0];
            sum_d   = i_Rx_Byte;
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (i_Rx_DV) begin
          tmo_d  = '0;
          buf_we = 1'b1;
          sum_d  = sum_q + i_Rx_Byte;
          idx_d  = idx_q + LenOne;
          if (idx_q == (len_q - LenOne)) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (i_Rx_DV) begin
          tmo_d = '0;
          if (i_Rx_Byte == sum_q) begin
            rd_idx_d = '0;
            state_d  = StDrain;
          end else begin
            err_d   = 1'b1;
            code_d  = ErrCsum;
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        // A byte arriving mid-drain has nowhere to go; flag it but keep draining.
        if (i_Rx_DV) begin
          err_d  = 1'b1;
          code_d = ErrOverrun;
        end
        if (i_Frame_Ready) begin
          if (last_byte) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            rd_idx_d = rd_idx_q + LenOne;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Inter-byte timeout; a strobe on the limit cycle was handled above and wins.
    if (in_frame && !i_Rx_DV) begin
      if (tmo_q == TmoLimit) begin
        err_d   = 1'b1;
        code_d  = ErrTimeout;
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      idx_q    <= '0;
      rd_idx_q <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      rd_idx_q <= rd_idx_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (buf_we) begin
      buf_q[idx_q[IW-1:0]] <= i_Rx_Byte;
    end
  end

  assign o_Frame_Valid = (state_q == StDrain);
  assign o_Frame_Byte  = o_Frame_Valid ? buf_q[rd_idx_q[IW-1:0]] : 8'h00;
  assign o_Frame_Last  = o_Frame_Valid && last_byte;
  assign o_Frame_Done  = done_q;
  assign o_Frame_Err   = err_q;
  assign o_Err_Code    = code_q;
  assign o_Busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//   Directed bench for uart_frame_parser with hand-computed expectations. Inputs change and
//   outputs are sampled on the falling clock edge.
module tb_uart_frame_parser;

  localparam int unsigned MaxLen = 16;
  localparam int unsigned Tmo    = 8700;

  logic       clk;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [7:0] f_byte;
  logic       f_valid;
  logic       f_ready;
  logic       f_last;
  logic       f_done;
  logic       f_err;
  logic [1:0] err_code;
  logic       busy;

  int unsigned n_checks;
  int unsigned n_errors;

  uart_frame_parser #(
    .MAX_LEN     (MaxLen),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(Tmo)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .o_Frame_Byte (f_byte),
    .o_Frame_Valid(f_valid),
    .i_Frame_Ready(f_ready),
    .o_Frame_Last (f_last),
    .o_Frame_Done (f_done),
    .o_Frame_Err  (f_err),
    .o_Err_Code   (err_code),
    .o_Busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Strobe one byte for a single cycle; returns on the falling edge after it was sampled.
  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    step();
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic check_out(input string tag, input logic [7:0] b, input logic v,
                           input logic l);
    check({tag, "_valid"}, 32'(f_valid), 32'(v));
    check({tag, "_byte"},  32'(f_byte),  32'(b));
    check({tag, "_last"},  32'(f_last),  32'(l));
  endtask

  initial begin
    int unsigned cnt;
    logic held_ok;

    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    rx_dv    = 1'b0;
    rx_byte  = 8'h00;
    f_ready  = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_valid", 32'(f_valid), 32'd0);
    check("rst_byte",  32'(f_byte),  32'd0);
    check("rst_last",  32'(f_last),  32'd0);
    check("rst_done",  32'(f_done),  32'd0);
    check("rst_err",   32'(f_err),   32'd0);
    check("rst_code",  32'(err_code), 32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    rst = 1'b0;
    step();

    // 1. Good frame, sum 03+11+22+33 = 69
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    check_out("t1_b0", 8'h11, 1'b1, 1'b0);
    check("t1_noerr", 32'(f_err), 32'd0);
    step();
    check_out("t1_b1", 8'h22, 1'b1, 1'b0);
    step();
    check_out("t1_b2", 8'h33, 1'b1, 1'b1);
    step();
    check("t1_done",   32'(f_done),  32'd1);
    check("t1_dvalid", 32'(f_valid), 32'd0);
    step();
    check("t1_done_pulse", 32'(f_done), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // 2. Bad checksum (correct would be 32)
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hFF);
    check("t2_err",   32'(f_err),    32'd1);
    check("t2_code",  32'(err_code), 32'd1);
    check("t2_valid", 32'(f_valid),  32'd0);
    step();
    check("t2_err_pulse", 32'(f_err), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // 3. Bad lengths, then a minimal good frame (sum 01+7E = 7F)
    send(8'hA5); send(8'h00);
    check("t3_len0_err",  32'(f_err),    32'd1);
    check("t3_len0_code", 32'(err_code), 32'd0);
    step();
    send(8'hA5); send(8'h11);
    check("t3_len17_err",  32'(f_err),    32'd1);
    check("t3_len17_code", 32'(err_code), 32'd0);
    check("t3_len17_busy", 32'(busy),     32'd0);
    step();
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    check_out("t3_good", 8'h7E, 1'b1, 1'b1);
    step();
    check("t3_done", 32'(f_done), 32'd1);

    // 4. Timeout: error lands exactly Tmo edges after the last strobe's edge
    step();
    send(8'hA5); send(8'h02); send(8'h10);
    cnt = 0;
    while (!f_err && cnt < Tmo + 10) begin
      step();
      cnt++;
    end
    check("t4_tmo_lat",  cnt, Tmo);
    check("t4_tmo_code", 32'(err_code), 32'd2);
    step();
    check("t4_tmo_idle", 32'(busy), 32'd0);

    // 4b. Strobe on the limit cycle beats the timeout (sum 02+10+20 = 32)
    send(8'hA5); send(8'h02); send(8'h10);
    held_ok = 1'b1;
    for (int i = 0; i < int'(Tmo) - 1; i++) begin
      step();
      if (f_err) held_ok = 1'b0;
    end
    check("t4b_no_early_err", 32'(held_ok), 32'd1);
    send(8'h20);
    check("t4b_no_err",  32'(f_err), 32'd0);
    check("t4b_busy",    32'(busy),  32'd1);
    send(8'h32);
    check_out("t4b_b0", 8'h10, 1'b1, 1'b0);
    step();
    check_out("t4b_b1", 8'h20, 1'b1, 1'b1);
    step();
    check("t4b_done", 32'(f_done), 32'd1);

    // 5. Backpressure with an overrun strobe mid-drain
    f_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    held_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        send(8'h55);
        check("t5_ovr_err",  32'(f_err),    32'd1);
        check("t5_ovr_code", 32'(err_code), 32'd3);
      end else begin
        step();
      end
      if (!f_valid || f_byte != 8'h11 || f_last) held_ok = 1'b0;
    end
    check("t5_hold", 32'(held_ok), 32'd1);
    f_ready = 1'b1;
    step();
    check_out("t5_b1", 8'h22, 1'b1, 1'b0);
    step();
    check_out("t5_b2", 8'h33, 1'b1, 1'b1);
    // Overrun on the final handshake cycle: Done and Err together
    send(8'h66);
    check("t5_done",      32'(f_done),   32'd1);
    check("t5_both_err",  32'(f_err),    32'd1);
    check("t5_both_code", 32'(err_code), 32'd3);
    step();

    // 6. Garbage ignored, reset mid-payload, then a good frame (sum 02+AB+CD = 7A)
    send(8'h00); send(8'hFF); send(8'h5A);
    check("t6_garbage_busy", 32'(busy), 32'd0);
    send(8'hA5); send(8'h03); send(8'h11);
    check("t6_payload_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_busy",  32'(busy),    32'd0);
    check("t6_rst_valid", 32'(f_valid), 32'd0);
    check("t6_rst_err",   32'(f_err),   32'd0);
    check("t6_rst_done",  32'(f_done),  32'd0);
    step();
    check("t6_post_err",  32'(f_err),  32'd0);
    check("t6_post_done", 32'(f_done), 32'd0);
    send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h7A);
    check_out("t6_b0", 8'hAB, 1'b1, 1'b0);
    step();
    check_out("t6_b1", 8'hCD, 1'b1, 1'b1);
    step();
    check("t6_done", 32'(f_done), 32'd1);
    check("t6_noerr", 32'(f_err), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
